// File: rtl/llc_pkg.sv
// Shared types and default sizes for the LLC set controller and its PLRU helper.
package llc_pkg;

  localparam int N_WAY_DEF = 16;
  localparam int N_SET_DEF = 64;
  localparam int TAG_W_DEF = 12;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_SNOOP_INV = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // The tag field is sized by the package default; the top casts to and from its own TAG_W.
  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    mesi_e                mesi;
  } way_meta_st;

endpackage

// File: rtl/llc_set_ctrl_if.sv
// Request/response bundle between a requester (master) and llc_set_ctrl (slave).
interface llc_set_ctrl_if
  import llc_pkg::*;
#(
  parameter int N_WAY = N_WAY_DEF,
  parameter int N_SET = N_SET_DEF,
  parameter int TAG_W = TAG_W_DEF
) ();

  logic                     req_valid;
  logic                     req_ready;
  op_e                      req_op;
  logic [$clog2(N_SET)-1:0] req_set;
  logic [TAG_W-1:0]         req_tag;
  logic                     req_shared;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_hit;
  logic [$clog2(N_WAY)-1:0] rsp_way;
  logic                     rsp_evict;
  logic [TAG_W-1:0]         rsp_evict_tag;
  logic                     rsp_evict_dirty;

  modport master (
    output req_valid, req_op, req_set, req_tag, req_shared, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, rsp_evict_dirty
  );

  modport slave (
    input  req_valid, req_op, req_set, req_tag, req_shared, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, rsp_evict_dirty
  );

endinterface

// File: rtl/llc_plru_tree.sv
// Combinational tree-PLRU for one set: next bits after touching a way, and the current victim.
module llc_plru_tree
  import llc_pkg::*;
#(
  parameter int N_WAY = N_WAY_DEF
) (
  input  logic [N_WAY-2:0]         plru_i,
  input  logic [$clog2(N_WAY)-1:0] touch_way_i,
  output logic [N_WAY-2:0]         plru_next_o,
  output logic [$clog2(N_WAY)-1:0] victim_o
);

  localparam int LW = $clog2(N_WAY);

  logic [LW-1:0] t_node;
  logic [LW-1:0] v_node;
  logic          t_bit;
  logic          v_bit;

  // Heap layout: children of node n are 2n+1 (bit 0) and 2n+2 (bit 1).
  always_comb begin
    plru_next_o = plru_i;
    t_node      = '0;
    t_bit       = 1'b0;
    for (int l = 0; l < LW; l++) begin
      t_bit               = touch_way_i[LW-1-l];
      plru_next_o[t_node] = t_bit;
      t_node              = LW'((32'(t_node) << 1) + 32'd1 + 32'(t_bit));
    end
  end

  always_comb begin
    victim_o = '0;
    v_node   = '0;
    v_bit    = 1'b0;
    for (int l = 0; l < LW; l++) begin
      v_bit              = ~plru_i[v_node];
      victim_o[LW-1-l]   = v_bit;
      v_node             = LW'((32'(v_node) << 1) + 32'd1 + 32'(v_bit));
    end
  end

endmodule

// File: rtl/llc_set_ctrl.sv
// Per-request LLC set controller: tag/MESI lookup, victim choice, fill and PLRU update.
// Optional hit/miss/dirty-evict counters are built when LLC_SET_CTRL_STATS_EN is defined.
module llc_set_ctrl
  import llc_pkg::*;
#(
  parameter int N_WAY = N_WAY_DEF,
  parameter int N_SET = N_SET_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  llc_set_ctrl_if.slave bus
`ifdef LLC_SET_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_misses,
  output logic [15:0]   stat_evict_dirty
`endif
);

  localparam int WAY_W = $clog2(N_WAY);
  localparam int SET_W = $clog2(N_SET);

  state_e                  state_q, state_d;
  op_e                     lk_op_q, lk_op_d;
  logic [SET_W-1:0]        lk_set_q, lk_set_d;
  logic [TAG_W-1:0]        lk_tag_q, lk_tag_d;
  logic                    lk_shared_q, lk_shared_d;
  logic                    hit_q, hit_d;
  logic [WAY_W-1:0]        way_q, way_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0]        rsp_way_q, rsp_way_d;
  logic                    rsp_evict_q, rsp_evict_d;
  logic [TAG_W-1:0]        rsp_evict_tag_q, rsp_evict_tag_d;
  logic                    rsp_evict_dirty_q, rsp_evict_dirty_d;

  way_meta_st [N_WAY-1:0]  meta_q [N_SET];
  logic [N_WAY-2:0]        plru_q [N_SET];
  way_meta_st [N_WAY-1:0]  row_d;
  logic [N_WAY-2:0]        plru_next;
  logic [WAY_W-1:0]        plru_victim;
  logic                    meta_we, plru_we, clr_all;
  way_meta_st              old_meta;
  logic                    old_valid;
  logic                    found_hit, found_inv;
  logic [WAY_W-1:0]        hit_way, inv_way;

  // One tree serves both states: victim is read in LOOKUP, next bits in UPDATE.
  llc_plru_tree #(.N_WAY(N_WAY)) u_plru (
    .plru_i      (plru_q[lk_set_q]),
    .touch_way_i (way_q),
    .plru_next_o (plru_next),
    .victim_o    (plru_victim)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
  end

  always_comb begin
    lk_op_d     = lk_op_q;
    lk_set_d    = lk_set_q;
    lk_tag_d    = lk_tag_q;
    lk_shared_d = lk_shared_q;
    if (state_q == ST_IDLE && bus.req_valid) begin
      lk_op_d     = bus.req_op;
      lk_set_d    = bus.req_set;
      lk_tag_d    = bus.req_tag;
      lk_shared_d = bus.req_shared;
    end
  end

  // LOOKUP: a hit outranks the lowest Invalid way, which outranks the PLRU victim.
  always_comb begin
    found_hit = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (meta_q[lk_set_q][w].mesi != MESI_I && TAG_W'(meta_q[lk_set_q][w].tag) == lk_tag_q) begin
        found_hit = 1'b1;
        hit_way   = WAY_W'(w);
      end
      if (!found_inv && meta_q[lk_set_q][w].mesi == MESI_I) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    hit_d = hit_q;
    way_d = way_q;
    if (state_q == ST_LOOKUP) begin
      hit_d = found_hit;
      way_d = found_hit ? hit_way : (found_inv ? inv_way : plru_victim);
    end
  end

  // UPDATE: arrays are untouched since LOOKUP, so the chosen way's old metadata is still current.
  always_comb begin
    old_meta          = meta_q[lk_set_q][way_q];
    old_valid         = (old_meta.mesi != MESI_I);
    row_d             = meta_q[lk_set_q];
    meta_we           = 1'b0;
    plru_we           = 1'b0;
    clr_all           = 1'b0;
    rsp_hit_d         = rsp_hit_q;
    rsp_way_d         = rsp_way_q;
    rsp_evict_d       = rsp_evict_q;
    rsp_evict_tag_d   = rsp_evict_tag_q;
    rsp_evict_dirty_d = rsp_evict_dirty_q;
    if (state_q == ST_UPDATE) begin
      rsp_hit_d         = 1'b0;
      rsp_way_d         = '0;
      rsp_evict_d       = 1'b0;
      rsp_evict_tag_d   = '0;
      rsp_evict_dirty_d = 1'b0;
      case (lk_op_q)
        OP_READ, OP_WRITE: begin
          meta_we   = 1'b1;
          plru_we   = 1'b1;
          rsp_hit_d = hit_q;
          rsp_way_d = way_q;
          if (!hit_q) begin
            row_d[way_q].tag  = TAG_W_DEF'(lk_tag_q);
            row_d[way_q].mesi = lk_shared_q ? MESI_S : MESI_E;
            rsp_evict_d       = old_valid;
            rsp_evict_tag_d   = old_valid ? TAG_W'(old_meta.tag) : '0;
            rsp_evict_dirty_d = (old_meta.mesi == MESI_M);
          end
          if (lk_op_q == OP_WRITE) row_d[way_q].mesi = MESI_M;
        end
        OP_SNOOP_INV: begin
          rsp_hit_d = hit_q;
          if (hit_q) begin
            meta_we           = 1'b1;
            row_d[way_q].mesi = MESI_I;
            rsp_way_d         = way_q;
            rsp_evict_dirty_d = (old_meta.mesi == MESI_M);
          end
        end
        default: clr_all = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_op_q           <= OP_READ;
      lk_set_q          <= '0;
      lk_tag_q          <= '0;
      lk_shared_q       <= 1'b0;
      hit_q             <= 1'b0;
      way_q             <= '0;
      rsp_hit_q         <= 1'b0;
      rsp_way_q         <= '0;
      rsp_evict_q       <= 1'b0;
      rsp_evict_tag_q   <= '0;
      rsp_evict_dirty_q <= 1'b0;
    end else begin
      lk_op_q           <= lk_op_d;
      lk_set_q          <= lk_set_d;
      lk_tag_q          <= lk_tag_d;
      lk_shared_q       <= lk_shared_d;
      hit_q             <= hit_d;
      way_q             <= way_d;
      rsp_hit_q         <= rsp_hit_d;
      rsp_way_q         <= rsp_way_d;
      rsp_evict_q       <= rsp_evict_d;
      rsp_evict_tag_q   <= rsp_evict_tag_d;
      rsp_evict_dirty_q <= rsp_evict_dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < N_SET; s++) begin
        meta_q[s] <= '0;
        plru_q[s] <= '0;
      end
    end else if (clr_all) begin
      for (int s = 0; s < N_SET; s++) begin
        for (int w = 0; w < N_WAY; w++) meta_q[s][w].mesi <= MESI_I;
        plru_q[s] <= '0;
      end
    end else begin
      if (meta_we) meta_q[lk_set_q] <= row_d;
      if (plru_we) plru_q[lk_set_q] <= plru_next;
    end
  end

  assign bus.rsp_hit         = rsp_hit_q;
  assign bus.rsp_way         = rsp_way_q;
  assign bus.rsp_evict       = rsp_evict_q;
  assign bus.rsp_evict_tag   = rsp_evict_tag_q;
  assign bus.rsp_evict_dirty = rsp_evict_dirty_q;

`ifdef LLC_SET_CTRL_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;
  logic [15:0] stat_evict_dirty_q, stat_evict_dirty_d;

  always_comb begin
    stat_hits_d        = stat_hits_q;
    stat_misses_d      = stat_misses_q;
    stat_evict_dirty_d = stat_evict_dirty_q;
    if (state_q == ST_UPDATE && (lk_op_q == OP_READ || lk_op_q == OP_WRITE)) begin
      if (hit_q && stat_hits_q != '1)   stat_hits_d   = stat_hits_q + 32'd1;
      if (!hit_q && stat_misses_q != '1) stat_misses_d = stat_misses_q + 32'd1;
      if (rsp_evict_dirty_d && stat_evict_dirty_q != '1)
        stat_evict_dirty_d = stat_evict_dirty_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits_q        <= '0;
      stat_misses_q      <= '0;
      stat_evict_dirty_q <= '0;
    end else begin
      stat_hits_q        <= stat_hits_d;
      stat_misses_q      <= stat_misses_d;
      stat_evict_dirty_q <= stat_evict_dirty_d;
    end
  end

  assign stat_hits        = stat_hits_q;
  assign stat_misses      = stat_misses_q;
  assign stat_evict_dirty = stat_evict_dirty_q;
`endif

endmodule

// File: tb/tb_llc_set_ctrl.sv
// Directed bench for llc_set_ctrl: hit/miss, victim choice, evictions, snoop, hold, reset, clear.
module tb_llc_set_ctrl;
  import llc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  llc_set_ctrl_if #(.N_WAY(16), .N_SET(64), .TAG_W(12)) bus ();

`ifdef LLC_SET_CTRL_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  logic [15:0] stat_evict_dirty;
  int sb_hits = 0;
  int sb_misses = 0;
  int sb_dirty = 0;
`endif

  llc_set_ctrl #(.N_WAY(16), .N_SET(64), .TAG_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LLC_SET_CTRL_STATS_EN
    ,
    .stat_hits        (stat_hits),
    .stat_misses      (stat_misses),
    .stat_evict_dirty (stat_evict_dirty)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One request/response transaction; negative e_way / e_dirty means "not checked".
  task automatic do_req(input string nm, input op_e op, input int set, input int tg, input bit sh,
                        input int hold, input bit e_hit, input int e_way, input bit e_ev,
                        input int e_etag, input int e_dirty);
    int n;
    bit stable;
    logic h_s, e_s, d_s;
    logic [3:0] w_s;
    logic [11:0] t_s;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_set    = 6'(set);
    bus.req_tag    = 12'(tg);
    bus.req_shared = sh;
    bus.rsp_ready  = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    check({nm, ":req_ready"}, 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    check({nm, ":rsp_valid"}, 32'(bus.rsp_valid), 1);
    check({nm, ":latency"}, n + 1, 3);
    check({nm, ":hit"}, 32'(bus.rsp_hit), 32'(e_hit));
    if (e_way >= 0) check({nm, ":way"}, 32'(bus.rsp_way), e_way);
    check({nm, ":evict"}, 32'(bus.rsp_evict), 32'(e_ev));
    if (e_ev) check({nm, ":evict_tag"}, 32'(bus.rsp_evict_tag), e_etag);
    if (e_dirty >= 0) check({nm, ":evict_dirty"}, 32'(bus.rsp_evict_dirty), e_dirty);
    if (hold > 0) begin
      h_s = bus.rsp_hit; w_s = bus.rsp_way; e_s = bus.rsp_evict;
      t_s = bus.rsp_evict_tag; d_s = bus.rsp_evict_dirty;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.req_ready || bus.rsp_hit !== h_s || bus.rsp_way !== w_s ||
            bus.rsp_evict !== e_s || bus.rsp_evict_tag !== t_s || bus.rsp_evict_dirty !== d_s)
          stable = 1'b0;
      end
      check({nm, ":hold_stable"}, 32'(stable), 1);
      bus.rsp_ready = 1'b1;
    end
`ifdef LLC_SET_CTRL_STATS_EN
    if (op == OP_READ || op == OP_WRITE) begin
      if (e_hit) sb_hits++; else sb_misses++;
      if (e_dirty == 1) sb_dirty++;
    end
`endif
    @(posedge clk);
    #1;
    check({nm, ":rsp_done"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_READ;
    bus.req_set    = '0;
    bus.req_tag    = '0;
    bus.req_shared = 1'b0;
    bus.rsp_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst:req_ready", 32'(bus.req_ready), 1);
    check("rst:rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst:rsp_hit", 32'(bus.rsp_hit), 0);
    check("rst:rsp_way", 32'(bus.rsp_way), 0);
    check("rst:rsp_evict", 32'(bus.rsp_evict), 0);
    check("rst:rsp_evict_tag", 32'(bus.rsp_evict_tag), 0);
    check("rst:rsp_evict_dirty", 32'(bus.rsp_evict_dirty), 0);
`ifdef LLC_SET_CTRL_STATS_EN
    check("rst:stat_hits", stat_hits, 0);
    check("rst:stat_misses", stat_misses, 0);
`endif

    // Set 5: first miss lands in way 0, then ways 1..15 fill in order.
    do_req("s5_first", OP_READ, 5, 'h0A1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    for (int w = 1; w < 16; w++)
      do_req("s5_fill", OP_READ, 5, 'h100 + w, 1'b0, 0, 1'b0, w, 1'b0, 0, 0);
    do_req("s5_rehit", OP_READ, 5, 'h0A1, 1'b0, 0, 1'b1, 0, 1'b0, 0, 0);
    // Touches 0..15 then 0 leave the PLRU pointing at way 8.
    do_req("s5_plru_evict", OP_READ, 5, 'h200, 1'b0, 0, 1'b0, 8, 1'b1, 'h108, 0);

    // Set 9: dirty way 3, then steer the PLRU onto it with hits to 2, 0, 4, 8.
    for (int w = 0; w < 16; w++)
      do_req("s9_fill", OP_READ, 9, 'h300 + w, 1'b0, 0, 1'b0, w, 1'b0, 0, 0);
    do_req("s9_write_hit", OP_WRITE, 9, 'h303, 1'b0, 0, 1'b1, 3, 1'b0, 0, 0);
    do_req("s9_touch2", OP_READ, 9, 'h302, 1'b0, 0, 1'b1, 2, 1'b0, 0, 0);
    do_req("s9_touch0", OP_READ, 9, 'h300, 1'b0, 0, 1'b1, 0, 1'b0, 0, 0);
    do_req("s9_touch4", OP_READ, 9, 'h304, 1'b0, 0, 1'b1, 4, 1'b0, 0, 0);
    do_req("s9_touch8", OP_READ, 9, 'h308, 1'b0, 0, 1'b1, 8, 1'b0, 0, 0);
    do_req("s9_dirty_evict", OP_READ, 9, 'h3F0, 1'b0, 0, 1'b0, 3, 1'b1, 'h303, 1);

    // Snoop invalidate of a Modified line, then refill of the freed way.
    do_req("s9_mk_m", OP_WRITE, 9, 'h3F0, 1'b0, 0, 1'b1, 3, 1'b0, 0, 0);
    do_req("s9_snoop_hit", OP_SNOOP_INV, 9, 'h3F0, 1'b0, 0, 1'b1, 3, 1'b0, 0, 1);
    do_req("s9_snoop_miss", OP_SNOOP_INV, 9, 'h777, 1'b0, 0, 1'b0, -1, 1'b0, 0, 0);
    do_req("s9_refill_inv", OP_READ, 9, 'h3F1, 1'b1, 0, 1'b0, 3, 1'b0, 0, 0);

    // Response back-pressure for 5 cycles.
    do_req("s9_hold", OP_READ, 9, 'h3F1, 1'b0, 5, 1'b1, 3, 1'b0, 0, 0);

    // Reset while the request sits in LOOKUP: it must vanish without a response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_READ;
    bus.req_set   = 6'd9;
    bus.req_tag   = 12'h3F2;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst:req_ready", 32'(bus.req_ready), 1);
    check("midrst:rsp_valid", 32'(bus.rsp_valid), 0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
    end
    check("midrst:no_rsp", 32'(saw), 0);
`ifdef LLC_SET_CTRL_STATS_EN
    sb_hits = 0; sb_misses = 0; sb_dirty = 0;
`endif
    do_req("post_rst_s9", OP_READ, 9, 'h3F1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    do_req("post_rst_s5", OP_READ, 5, 'h0A1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);

    // Mixed traffic in set 12, then CLEAR_ALL: everything misses afterwards.
    do_req("s12_rd", OP_READ, 12, 'h500, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    do_req("s12_wr", OP_WRITE, 12, 'h501, 1'b0, 0, 1'b0, 1, 1'b0, 0, 0);
    do_req("s12_rdhit", OP_READ, 12, 'h500, 1'b0, 0, 1'b1, 0, 1'b0, 0, 0);
    do_req("clear_all", OP_CLEAR_ALL, 0, 0, 1'b0, 0, 1'b0, -1, 1'b0, 0, -1);
    do_req("s12_after_clr0", OP_READ, 12, 'h500, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    do_req("s12_after_clr1", OP_READ, 12, 'h501, 1'b0, 0, 1'b0, 1, 1'b0, 0, 0);
    do_req("s9_after_clr", OP_READ, 9, 'h3F1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);

`ifdef LLC_SET_CTRL_STATS_EN
    check("stat_hits", stat_hits, 32'(sb_hits));
    check("stat_misses", stat_misses, 32'(sb_misses));
    check("stat_evict_dirty", 32'(stat_evict_dirty), 32'(sb_dirty));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
